// File: rtl/sysctrl_gen.sv
// rtl/sysctrl_gen.sv - MCU system-control endpoint: byte-stream command decoder, config slots, interrupts
// Optional SYSCTRL_CFG_READBACK_EN enables command 7 (config slot readback).
module sysctrl_gen #(
  parameter logic [7:0]             CORE_ID   = 8'h01,
  parameter int                     INT_W     = 8,
  parameter int                     NUM_LEDS  = 2,
  parameter int                     NUM_BTNS  = 2,
  parameter int                     CFG_SLOTS = 26,
  parameter logic [CFG_SLOTS*8-1:0] CFG_RST   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   data_in_strobe,
  input  logic                   data_in_start,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  input  logic [INT_W-1:0]       int_in,
  output logic                   int_out_n,
  input  logic [NUM_BTNS-1:0]    buttons,
  output logic [NUM_LEDS-1:0]    leds,
  output logic [23:0]            color,
  output logic [CFG_SLOTS*8-1:0] cfg_out,
  output logic                   cfg_wr,
  output logic [4:0]             cfg_wr_id
);

`ifdef SYSCTRL_CFG_READBACK_EN
  localparam logic [7:0] STATUS4 = 8'h82;
`else
  localparam logic [7:0] STATUS4 = 8'h02;
`endif

  logic [3:0]             state_q, state_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [7:0]             id_q, id_d;
  logic [7:0]             data_out_q, data_out_d;
  logic [NUM_LEDS-1:0]    leds_q, leds_d;
  logic [23:0]            color_q, color_d;
  logic [CFG_SLOTS*8-1:0] cfg_q, cfg_d;
  logic                   cfg_wr_q, cfg_wr_d;
  logic [4:0]             cfg_wr_id_q, cfg_wr_id_d;
  logic [INT_W-1:0]       pending_q, pending_d;
  logic [INT_W-1:0]       mask_q, mask_d;
  logic [INT_W-1:0]       int_in_q;

  logic [7:0]       data_rev;
  logic [7:0]       slot_off;
  logic [7:0]       btn_ext;
  logic [7:0]       irq_ext;
  logic [INT_W-1:0] ack;
  logic [INT_W-1:0] rise;

`ifdef SYSCTRL_CFG_READBACK_EN
  function automatic logic [7:0] rd_slot(input logic [7:0] idx, input logic [CFG_SLOTS*8-1:0] tbl);
    logic [7:0] off;
    logic [7:0] val;
    off = idx - 8'h41;
    val = 8'h00;
    for (int n = 0; n < CFG_SLOTS; n++)
      if (off == 8'(n)) val = tbl[n*8 +: 8];
    return val;
  endfunction
`endif

  always_comb begin
    for (int i = 0; i < 8; i++) data_rev[i] = data_in[7-i];
    btn_ext = '0;
    btn_ext[NUM_BTNS-1:0] = buttons;
    irq_ext = '0;
    irq_ext[INT_W-1:0] = pending_q & mask_q;
    // ids below 'A' wrap to large offsets and fall out of range
    slot_off = id_q - 8'h41;
    rise = int_in & ~int_in_q;
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    id_d        = id_q;
    data_out_d  = data_out_q;
    leds_d      = leds_q;
    color_d     = color_q;
    cfg_d       = cfg_q;
    cfg_wr_d    = 1'b0;
    cfg_wr_id_d = cfg_wr_id_q;
    mask_d      = mask_q;
    ack         = '0;
    if (data_in_strobe) begin
      if (data_in_start) begin
        cmd_d      = data_in;
        state_d    = 4'd1;
        data_out_d = 8'h00;
      end else if (state_q != 4'd0) begin
        if (state_q != 4'd15) state_d = state_q + 4'd1;
        case (cmd_q)
          8'h00: begin
            case (state_q)
              4'd1:    data_out_d = 8'h5C;
              4'd2:    data_out_d = 8'h42;
              4'd3:    data_out_d = CORE_ID;
              4'd4:    data_out_d = STATUS4;
              default: data_out_d = 8'h00;
            endcase
          end
          8'h01: if (state_q == 4'd1) leds_d = data_in[NUM_LEDS-1:0];
          8'h02: begin
            case (state_q)
              4'd1:    color_d[15:8]  = data_rev;
              4'd2:    color_d[7:0]   = data_rev;
              4'd3:    color_d[23:16] = data_rev;
              default: ;
            endcase
          end
          8'h03: data_out_d = btn_ext;
          8'h04: begin
            if (state_q == 4'd1) begin
              id_d = data_in;
            end else if (state_q == 4'd2 && slot_off < 8'(CFG_SLOTS)) begin
              for (int n = 0; n < CFG_SLOTS; n++)
                if (slot_off == 8'(n)) cfg_d[n*8 +: 8] = data_in;
              cfg_wr_d    = 1'b1;
              cfg_wr_id_d = slot_off[4:0];
            end
          end
          8'h05: begin
            data_out_d = irq_ext;
            if (state_q == 4'd1) ack = data_in[INT_W-1:0];
          end
          8'h06: if (state_q == 4'd1) mask_d = data_in[INT_W-1:0];
`ifdef SYSCTRL_CFG_READBACK_EN
          8'h07: begin
            if (state_q == 4'd1) begin
              id_d       = data_in;
              data_out_d = rd_slot(data_in, cfg_q);
            end else begin
              id_d       = id_q + 8'd1;
              data_out_d = rd_slot(id_q + 8'd1, cfg_q);
            end
          end
`endif
          default: data_out_d = 8'h00;
        endcase
      end
    end
    // a fresh edge on a bit being acknowledged keeps it pending
    pending_d = (pending_q & ~ack) | rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= '0;
      cmd_q       <= '0;
      id_q        <= '0;
      data_out_q  <= '0;
      leds_q      <= '0;
      color_q     <= '0;
      cfg_q       <= CFG_RST;
      cfg_wr_q    <= 1'b0;
      cfg_wr_id_q <= '0;
      pending_q   <= '0;
      mask_q      <= '1;
      int_in_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      id_q        <= id_d;
      data_out_q  <= data_out_d;
      leds_q      <= leds_d;
      color_q     <= color_d;
      cfg_q       <= cfg_d;
      cfg_wr_q    <= cfg_wr_d;
      cfg_wr_id_q <= cfg_wr_id_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      int_in_q    <= int_in;
    end
  end

  assign data_out  = data_out_q;
  assign leds      = leds_q;
  assign color     = color_q;
  assign cfg_out   = cfg_q;
  assign cfg_wr    = cfg_wr_q;
  assign cfg_wr_id = cfg_wr_id_q;
  assign int_out_n = ~|(pending_q & mask_q);

endmodule

// File: tb/tb_sysctrl_gen.sv
// tb/tb_sysctrl_gen.sv - directed self-checking bench for sysctrl_gen
module tb_sysctrl_gen;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         data_in_strobe = 1'b0;
  logic         data_in_start = 1'b0;
  logic [7:0]   data_in = 8'h00;
  logic [7:0]   data_out;
  logic [7:0]   int_in = 8'h00;
  logic         int_out_n;
  logic [1:0]   buttons = 2'b00;
  logic [1:0]   leds;
  logic [23:0]  color;
  logic [207:0] cfg_out;
  logic         cfg_wr;
  logic [4:0]   cfg_wr_id;

  int checks = 0;
  int errors = 0;

`ifdef SYSCTRL_CFG_READBACK_EN
  localparam logic [7:0] EXP_ST4 = 8'h82;
  localparam logic [7:0] EXP_C7  = 8'h01;
`else
  localparam logic [7:0] EXP_ST4 = 8'h02;
  localparam logic [7:0] EXP_C7  = 8'h00;
`endif

  sysctrl_gen dut (
    .clk            (clk),
    .reset          (reset),
    .data_in_strobe (data_in_strobe),
    .data_in_start  (data_in_start),
    .data_in        (data_in),
    .data_out       (data_out),
    .int_in         (int_in),
    .int_out_n      (int_out_n),
    .buttons        (buttons),
    .leds           (leds),
    .color          (color),
    .cfg_out        (cfg_out),
    .cfg_wr         (cfg_wr),
    .cfg_wr_id      (cfg_wr_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic start, input logic [7:0] b);
    @(negedge clk);
    data_in_strobe = 1'b1;
    data_in_start  = start;
    data_in        = b;
    @(negedge clk);
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle();
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_color", 32'(color), 32'h0);
    check("rst_cfg_or", 32'(|cfg_out), 32'h0);
    check("rst_cfg_wr", 32'(cfg_wr), 32'h0);
    check("rst_int_out_n", 32'(int_out_n), 32'h1);

    send(1'b1, 8'h00);
    send(1'b0, 8'h11); check("status1", 32'(data_out), 32'h5C);
    send(1'b0, 8'h22); check("status2", 32'(data_out), 32'h42);
    send(1'b0, 8'h33); check("status3", 32'(data_out), 32'h01);
    send(1'b0, 8'h44); check("status4", 32'(data_out), 32'(EXP_ST4));
    send(1'b0, 8'h55); check("status5", 32'(data_out), 32'h00);

    send(1'b1, 8'h01); send(1'b0, 8'h03);
    check("leds", 32'(leds), 32'h3);

    buttons = 2'b10;
    send(1'b1, 8'h03); send(1'b0, 8'h00);
    check("buttons", 32'(data_out), 32'h02);

    send(1'b1, 8'h04); send(1'b0, 8'h4D); send(1'b0, 8'h01);
    check("cfg_wr_pulse", 32'(cfg_wr), 32'h1);
    check("cfg_wr_id", 32'(cfg_wr_id), 32'd12);
    check("cfg_slot12", 32'(cfg_out[12*8 +: 8]), 32'h01);
    idle();
    check("cfg_wr_drop", 32'(cfg_wr), 32'h0);

    send(1'b1, 8'h04); send(1'b0, 8'h5B); send(1'b0, 8'h55);
    check("cfg_oor_nowr", 32'(cfg_wr), 32'h0);
    check("cfg_oor_id", 32'(cfg_wr_id), 32'd12);
    check("cfg_oor_s25", 32'(cfg_out[25*8 +: 8]), 32'h00);
    check("cfg_oor_s12", 32'(cfg_out[12*8 +: 8]), 32'h01);

    send(1'b1, 8'h07); send(1'b0, 8'h4D);
    check("cmd7", 32'(data_out), 32'(EXP_C7));
    send(1'b1, 8'h09); send(1'b0, 8'h12);
    check("unknown_cmd", 32'(data_out), 32'h00);

    int_in = 8'h04;
    idle();
    check("irq2_latched", 32'(int_out_n), 32'h0);
    send(1'b1, 8'h05); send(1'b0, 8'h04);
    check("irq_reply", 32'(data_out), 32'h04);
    check("irq_acked", 32'(int_out_n), 32'h1);
    send(1'b0, 8'hFF);
    check("irq_k2_reply", 32'(data_out), 32'h00);

    send(1'b1, 8'h05);
    @(negedge clk);
    int_in = 8'h05;
    data_in_strobe = 1'b1;
    data_in = 8'h01;
    @(negedge clk);
    data_in_strobe = 1'b0;
    check("rise_ack_reply", 32'(data_out), 32'h00);
    check("rise_ack_set_wins", 32'(int_out_n), 32'h0);
    send(1'b1, 8'h05); send(1'b0, 8'h01);
    check("irq0_reply", 32'(data_out), 32'h01);
    check("irq0_acked", 32'(int_out_n), 32'h1);

    send(1'b1, 8'h06); send(1'b0, 8'h00);
    int_in = 8'h07; idle();
    int_in = 8'h05; idle();
    check("masked_pend", 32'(int_out_n), 32'h1);
    send(1'b1, 8'h06); send(1'b0, 8'hFF);
    check("unmask_asserts", 32'(int_out_n), 32'h0);
    send(1'b1, 8'h05); send(1'b0, 8'hFF);
    check("irq1_reply", 32'(data_out), 32'h02);
    check("irq1_acked", 32'(int_out_n), 32'h1);

    send(1'b1, 8'h02); send(1'b0, 8'h01); send(1'b0, 8'h02); send(1'b0, 8'h03);
    check("color_full", 32'(color), 32'h00C08040);
    send(1'b1, 8'h02); send(1'b0, 8'hAA);
    check("color_partial", 32'(color), 32'h00C05540);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_color", 32'(color), 32'h0);
    check("midrst_leds", 32'(leds), 32'h0);
    reset = 1'b0;
    check("rel_int_out_n", 32'(int_out_n), 32'h1);
    idle();
    check("rel_line_latched", 32'(int_out_n), 32'h0);
    send(1'b0, 8'h03);
    check("nostart_color", 32'(color), 32'h0);
    check("nostart_data", 32'(data_out), 32'h0);
    check("rst_cfg_cleared", 32'(cfg_out[12*8 +: 8]), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
